// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg
// Shared definitions for the load/store unit:
//   DATA_W         - data path width (64)
//   SZ_B..SZ_D     - request size encodings (byte, half, word, double)
//   state_e        - LSU controller states
//   is_misaligned  - natural-alignment check of a byte offset against a size
package mem_lsu_pkg;

    localparam int DATA_W = 64;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } state_e;

    // An access is misaligned when the low log2(bytes) address bits are non-zero.
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = |addr_lo[1:0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align
// Purely combinational lane steering for the LSU.
//   addr_lo     in  byte offset inside the 8-byte memory word
//   size        in  access size (SZ_B..SZ_D)
//   is_unsigned in  1 = zero-extend loads, 0 = sign-extend
//   st_data     in  right-justified store data
//   ld_raw      in  raw 64-bit memory read word
//   lane_wdata  out store data moved onto its byte lanes
//   lane_wmask  out byte-lane write enables
//   ld_data     out extracted and extended load data
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [2:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] ld_raw,
    output logic [DATA_W-1:0] lane_wdata,
    output logic [7:0]        lane_wmask,
    output logic [DATA_W-1:0] ld_data
);

    logic [5:0]        shamt;
    logic [7:0]        mask_base;
    logic [DATA_W-1:0] ld_shift;
    logic              fill;

    always_comb begin
        shamt      = {addr_lo, 3'b000};
        lane_wdata = st_data << shamt;

        case (size)
            SZ_B:    mask_base = 8'h01;
            SZ_H:    mask_base = 8'h03;
            SZ_W:    mask_base = 8'h0F;
            default: mask_base = 8'hFF;
        endcase
        // 8-bit shift drops any lanes pushed past byte 7.
        lane_wmask = mask_base << addr_lo;

        // Loads: move the addressed byte to bit 0, keep the access width, extend.
        ld_shift = ld_raw >> shamt;
        fill     = 1'b0;
        case (size)
            SZ_B: begin
                fill    = ~is_unsigned & ld_shift[7];
                ld_data = {{56{fill}}, ld_shift[7:0]};
            end
            SZ_H: begin
                fill    = ~is_unsigned & ld_shift[15];
                ld_data = {{48{fill}}, ld_shift[15:0]};
            end
            SZ_W: begin
                fill    = ~is_unsigned & ld_shift[31];
                ld_data = {{32{fill}}, ld_shift[31:0]};
            end
            default: begin
                ld_data = ld_shift;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu
// Single-outstanding load/store unit between a core request/response port
// and a 64-bit memory with one-cycle read latency and hit/miss retry.
//   clock, reset           clock and asynchronous active-low reset
//   req_*                  core request (valid/ready handshake)
//   resp_*                 core response (valid/ready handshake), err = misaligned
//   ioMem_ren/addr         read strobe and 8-byte-aligned address
//   ioMem_rData/rvalid/hit read return; a miss triggers a re-issue
//   ioMem_wen/wData/wMask  single-cycle lane-aligned write
// All outputs come straight from flops; their next values are derived from
// the next state so each output lines up with the state it belongs to.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              ioMem_ren,
    output logic [31:0]       ioMem_addr,
    input  logic [DATA_W-1:0] ioMem_rData,
    input  logic              ioMem_rvalid,
    input  logic              ioMem_hit,
    output logic              ioMem_wen,
    output logic [DATA_W-1:0] ioMem_wData,
    output logic [7:0]        ioMem_wMask
);

    state_e            state_q, state_d;
    logic              wen_q, wen_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_ren_q, mem_ren_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic              mem_wen_q, mem_wen_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]        mem_wmask_q, mem_wmask_d;

    logic [DATA_W-1:0] lane_wdata;
    logic [7:0]        lane_wmask;
    logic [DATA_W-1:0] ld_data;

    // Next state and the latched request fields.
    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (is_misaligned(req_addr[2:0], req_size)) begin
                        state_d = RESP;
                    end else if (req_wen) begin
                        state_d = WR;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: begin
                if (ioMem_rvalid) begin
                    state_d = ioMem_hit ? RESP : RD_REQ;
                end
            end
            WR:      state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fed with the next-cycle request fields; in RD_WAIT these equal the latched ones.
    mem_lsu_align u_align (
        .addr_lo     (addr_d[2:0]),
        .size        (size_d),
        .is_unsigned (uns_d),
        .st_data     (wdata_d),
        .ld_raw      (ioMem_rData),
        .lane_wdata  (lane_wdata),
        .lane_wmask  (lane_wmask),
        .ld_data     (ld_data)
    );

    // Output values for the state being entered.
    always_comb begin
        req_ready_d  = (state_d == IDLE);
        mem_ren_d    = (state_d == RD_REQ);
        mem_wen_d    = (state_d == WR);
        mem_addr_d   = 32'h0;
        mem_wdata_d  = '0;
        mem_wmask_d  = 8'h00;
        resp_valid_d = (state_d == RESP);
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;

        if (state_d == RD_REQ || state_d == WR) begin
            mem_addr_d = {addr_d[31:3], 3'b000};
        end
        if (state_d == WR) begin
            mem_wdata_d = lane_wdata;
            mem_wmask_d = lane_wmask;
        end
        if (state_d == RESP) begin
            case (state_q)
                RESP: begin
                    resp_rdata_d = resp_rdata_q;
                    resp_err_d   = resp_err_q;
                end
                RD_WAIT: resp_rdata_d = ld_data;
                // Only a misaligned request jumps straight from IDLE to RESP.
                IDLE:    resp_err_d   = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wen_q        <= 1'b0;
            addr_q       <= 32'h0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_ren_q    <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wen_q    <= 1'b0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_ren_q    <= mem_ren_d;
            mem_addr_q   <= mem_addr_d;
            mem_wen_q    <= mem_wen_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign ioMem_ren   = mem_ren_q;
    assign ioMem_addr  = mem_addr_q;
    assign ioMem_wen   = mem_wen_q;
    assign ioMem_wData = mem_wdata_q;
    assign ioMem_wMask = mem_wmask_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu
// Directed bench for mem_lsu: a one-cycle-latency memory with a controllable
// miss, a byte-level reference model evaluated in one compare process, and
// hand-computed literal expectations attached to each directed request.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clock;
    logic        reset;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic        ioMem_ren, ioMem_rvalid, ioMem_hit, ioMem_wen;
    logic [31:0] ioMem_addr;
    logic [63:0] ioMem_rData, ioMem_wData;
    logic [7:0]  ioMem_wMask;

    mem_lsu dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ioMem_ren    (ioMem_ren),
        .ioMem_addr   (ioMem_addr),
        .ioMem_rData  (ioMem_rData),
        .ioMem_rvalid (ioMem_rvalid),
        .ioMem_hit    (ioMem_hit),
        .ioMem_wen    (ioMem_wen),
        .ioMem_wData  (ioMem_wData),
        .ioMem_wMask  (ioMem_wMask)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- memory model: 4 words, one-cycle read latency ----------
    logic [63:0] mem [0:3];
    int rd_count;
    int miss_idx;   // read number (rd_count value) that returns a miss

    always @(posedge clock) begin
        if (!reset) begin
            mem[0]       <= 64'h11223344_5566F788;
            mem[1]       <= 64'h0;
            mem[2]       <= 64'hCAFEF00D_0BADC0DE;
            mem[3]       <= 64'h0;
            ioMem_rvalid <= 1'b0;
            ioMem_hit    <= 1'b0;
            ioMem_rData  <= 64'h0;
        end else begin
            ioMem_rvalid <= ioMem_ren;
            if (ioMem_ren) begin
                ioMem_rData <= mem[ioMem_addr[4:3]];
                ioMem_hit   <= (rd_count != miss_idx);
                rd_count    <= rd_count + 1;
            end else begin
                ioMem_rData <= 64'h0;
                ioMem_hit   <= 1'b0;
            end
            if (ioMem_wen) begin
                for (int b = 0; b < 8; b++) begin
                    if (ioMem_wMask[b]) mem[ioMem_addr[4:3]][8*b +: 8] <= ioMem_wData[8*b +: 8];
                end
            end
        end
    end

    // ---------------- reference model (byte view) ----------------------------
    function automatic logic [63:0] model_load(input logic [63:0] word, input int off,
                                               input int n, input logic uns);
        logic [63:0] v;
        v = 64'h0;
        for (int i = 0; i < n; i++) begin
            if (off + i < 8) v[8*i +: 8] = word[8*(off+i) +: 8];
        end
        if (!uns && n < 8 && v[8*n-1]) begin
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    function automatic logic [7:0] model_mask(input int off, input int n);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (off + i < 8) m[off+i] = 1'b1;
        end
        return m;
    endfunction

    // ---------------- literal expectations set by the stimulus --------------
    logic        lit_en;
    logic [63:0] lit_rdata, lit_wdata;
    logic [7:0]  lit_mask;
    int          lit_reads, lit_lat;

    // ---------------- compare process ----------------------------------------
    int n_checks;
    int n_fail;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    logic        act, t_wen, t_mis, exp_err, resp_seen, t_lit;
    int          t_acc, t_off, t_n, reads, wens, t_lreads, t_llat;
    logic [31:0] t_addr;
    logic [63:0] t_wdata, exp_rdata, t_lrd, t_lwd;
    logic [7:0]  t_lmask;

    initial begin
        act = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("rst_ready", 64'(req_ready), 64'd1);
                chk("rst_ctl", 64'({ioMem_ren, ioMem_wen, resp_valid, resp_err}), 64'd0);
                chk("rst_rdata", resp_rdata, 64'd0);
                chk("rst_wdata", ioMem_wData, 64'd0);
                chk("rst_addr_mask", 64'({ioMem_addr, ioMem_wMask}), 64'd0);
                act = 1'b0;
            end else begin
                chk("ren_wen_excl", 64'(ioMem_ren & ioMem_wen), 64'd0);
                if (!act) begin
                    chk("idle_outs", 64'({req_ready, resp_valid, ioMem_ren, ioMem_wen}), 64'b1000);
                    if (req_valid && req_ready) begin
                        act       = 1'b1;
                        t_acc     = cyc;
                        t_wen     = req_wen;
                        t_addr    = req_addr;
                        t_wdata   = req_wdata;
                        t_off     = int'(req_addr[2:0]);
                        t_n       = 1 << req_size;
                        t_mis     = (t_off % t_n) != 0;
                        exp_err   = t_mis;
                        exp_rdata = (t_mis || t_wen) ? 64'h0 :
                                    model_load(mem[req_addr[4:3]], t_off, t_n, req_unsigned);
                        reads     = 0;
                        wens      = 0;
                        resp_seen = 1'b0;
                        t_lit     = lit_en;
                        t_lrd     = lit_rdata;
                        t_lwd     = lit_wdata;
                        t_lmask   = lit_mask;
                        t_lreads  = lit_reads;
                        t_llat    = lit_lat;
                    end
                end else begin
                    chk("busy_ready", 64'(req_ready), 64'd0);
                    if (ioMem_ren) begin
                        chk("ren_legal", 64'(!t_wen && !t_mis), 64'd1);
                        chk("ren_addr", 64'(ioMem_addr), 64'(t_addr - 32'(t_off)));
                        reads++;
                        if (reads == 1) chk("ren_lat", 64'(cyc - t_acc), 64'd1);
                    end
                    if (ioMem_wen) begin
                        wens++;
                        chk("wen_legal", 64'(t_wen && !t_mis), 64'd1);
                        chk("wen_lat", 64'(cyc - t_acc), 64'd1);
                        chk("wen_addr", 64'(ioMem_addr), 64'(t_addr - 32'(t_off)));
                        chk("wmask", 64'(ioMem_wMask), 64'(model_mask(t_off, t_n)));
                        chk("wdata", ioMem_wData, t_wdata << (8 * t_off));
                        if (t_lit) begin
                            chk("wmask_lit", 64'(ioMem_wMask), 64'(t_lmask));
                            chk("wdata_lit", ioMem_wData, t_lwd);
                        end
                    end
                    if (resp_seen) chk("resp_held", 64'(resp_valid), 64'd1);
                    if (resp_valid) begin
                        chk("rdata", resp_rdata, exp_rdata);
                        chk("err", 64'(resp_err), 64'(exp_err));
                        if (!resp_seen) begin
                            chk("wen_count", 64'(wens), 64'(t_wen && !t_mis));
                            if (t_lit) begin
                                chk("resp_lat", 64'(cyc - t_acc), 64'(t_llat));
                                chk("rdata_lit", resp_rdata, t_lrd);
                                chk("ren_count", 64'(reads), 64'(t_lreads));
                            end
                        end
                        resp_seen = 1'b1;
                        if (resp_ready) act = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic run(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wdata, input logic [63:0] l_rdata,
                       input logic [7:0] l_mask, input logic [63:0] l_wdata,
                       input int l_reads, input int l_lat, input int hold);
        int k;
        lit_en     = 1'b1;
        lit_rdata  = l_rdata;
        lit_mask   = l_mask;
        lit_wdata  = l_wdata;
        lit_reads  = l_reads;
        lit_lat    = l_lat;
        resp_ready = (hold == 0);
        @(posedge clock); #1;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        for (k = 0; k < 40; k++) begin
            @(negedge clock);
            if (req_ready) break;
        end
        if (k == 40) begin
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 40 cycles");
            $fatal(1);
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        if (hold > 0) begin
            for (k = 0; k < 40; k++) begin
                @(negedge clock);
                if (resp_valid) break;
            end
            repeat (hold) @(posedge clock);
            #1 resp_ready = 1'b1;
        end
        for (k = 0; k < 40; k++) begin
            @(negedge clock);
            if (resp_valid && resp_ready) break;
        end
        if (k == 40) begin
            $display("FAIL resp_timeout: got no response expected one within 40 cycles");
            $fatal(1);
        end
        $display("txn %s addr=%08h size=%0d rdata=%016h err=%0b", wen ? "ST" : "LD",
                 addr, size, resp_rdata, resp_err);
        @(posedge clock); #1;
        resp_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 64'h0; resp_ready = 1'b1; miss_idx = -1;
        lit_en = 1'b0; lit_rdata = 64'h0; lit_mask = 8'h0; lit_wdata = 64'h0;
        lit_reads = 0; lit_lat = 0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);

        // loads from 0x80000000 = 11223344_5566F788
        run(1'b0, 32'h80000000, SZ_B, 1'b0, 64'h0, 64'hFFFFFFFF_FFFFFF88, 8'h0, 64'h0, 1, 3, 0);
        run(1'b0, 32'h80000006, SZ_H, 1'b1, 64'h0, 64'h00000000_00001122, 8'h0, 64'h0, 1, 3, 0);
        run(1'b0, 32'h80000000, SZ_H, 1'b0, 64'h0, 64'hFFFFFFFF_FFFFF788, 8'h0, 64'h0, 1, 3, 0);
        run(1'b0, 32'h80000002, SZ_H, 1'b0, 64'h0, 64'h00000000_00005566, 8'h0, 64'h0, 1, 3, 0);
        run(1'b0, 32'h80000000, SZ_D, 1'b0, 64'h0, 64'h11223344_5566F788, 8'h0, 64'h0, 1, 3, 0);
        // word store then read back (signed)
        run(1'b1, 32'h80000004, SZ_W, 1'b0, 64'hDEADBEEF, 64'h0, 8'hF0, 64'hDEADBEEF_00000000, 0, 2, 0);
        run(1'b0, 32'h80000004, SZ_W, 1'b0, 64'h0, 64'hFFFFFFFF_DEADBEEF, 8'h0, 64'h0, 1, 3, 0);
        // misaligned load / store / double
        run(1'b0, 32'h80000003, SZ_W, 1'b0, 64'h0, 64'h0, 8'h0, 64'h0, 0, 1, 0);
        run(1'b1, 32'h80000001, SZ_H, 1'b0, 64'h1234, 64'h0, 8'h0, 64'h0, 0, 1, 0);
        run(1'b0, 32'h80000004, SZ_D, 1'b0, 64'h0, 64'h0, 8'h0, 64'h0, 0, 1, 0);
        // first read misses, second hits
        miss_idx = rd_count;
        run(1'b0, 32'h80000000, SZ_W, 1'b1, 64'h0, 64'h00000000_5566F788, 8'h0, 64'h0, 2, 5, 0);
        miss_idx = -1;
        // byte and double stores, unsigned word read-back
        run(1'b1, 32'h80000013, SZ_B, 1'b0, 64'hAB, 64'h0, 8'h08, 64'h00000000_AB000000, 0, 2, 0);
        run(1'b1, 32'h80000018, SZ_D, 1'b0, 64'h01234567_89ABCDEF, 64'h0, 8'hFF,
            64'h01234567_89ABCDEF, 0, 2, 0);
        run(1'b0, 32'h8000001C, SZ_W, 1'b1, 64'h0, 64'h00000000_01234567, 8'h0, 64'h0, 1, 3, 0);
        // response held 5 cycles with resp_ready low
        run(1'b0, 32'h80000013, SZ_B, 1'b0, 64'h0, 64'hFFFFFFFF_FFFFFFAB, 8'h0, 64'h0, 1, 3, 5);

        // reset pulled low while the load waits in RD_WAIT
        lit_en = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h80000000; req_size = SZ_D;
        req_unsigned = 1'b0;
        @(negedge clock);
        @(posedge clock); #1 req_valid = 1'b0;
        @(posedge clock); #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        repeat (6) @(posedge clock);
        $display("txn LD addr=80000000 size=3 aborted by reset");
        // recovery after reset; memory model reloads its initial contents
        run(1'b0, 32'h80000000, SZ_B, 1'b0, 64'h0, 64'hFFFFFFFF_FFFFFF88, 8'h0, 64'h0, 1, 3, 0);

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
